ram_loader: RTL

RAM_LOADER -- requirements
Module: ram_loader

---
 rtl/ram_loader.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/ram_loader.sv
// Loads DEPTH program bytes from a byte stream into an external RAM, then reads
// them back and compares the read-back sum against the running write checksum.
module ram_loader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start,
    input  logic [DATA_W-1:0] in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] wdata,
    output logic              WE,
    output logic              OE,
    input  logic [DATA_W-1:0] Mem_out,
    output logic              HLT,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] checksum
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_VERIFY,
        S_CHECK,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] vsum;
    logic              last_addr;

    function automatic logic [DATA_W-1:0] wrap_add(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        return a + b;
    endfunction

    assign last_addr = (Address == ADDR_LAST);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Handshake and RAM strobes decode straight from the state so that an
    // asynchronous reset drops them without waiting for a clock edge.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        WE        = 1'b0;
        OE        = 1'b0;
        busy      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) state_nxt = S_WRITE;
            end
            S_WRITE: begin
                WE   = 1'b1;
                busy = 1'b1;
                state_nxt = last_addr ? S_VERIFY : S_LOAD;
            end
            S_VERIFY: begin
                OE   = 1'b1;
                busy = 1'b1;
                if (last_addr) state_nxt = S_CHECK;
            end
            S_CHECK: begin
                busy      = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                if (start) state_nxt = S_LOAD;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign HLT = busy;

    // done is raised one edge after entering DONE, so err has already settled
    // when a host first observes completion.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            Address  <= '0;
            wdata    <= '0;
            checksum <= '0;
            vsum     <= '0;
            err      <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        Address  <= '0;
                        checksum <= '0;
                        vsum     <= '0;
                        err      <= 1'b0;
                        done     <= 1'b0;
                    end else if (state == S_DONE) begin
                        done <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        wdata    <= in;
                        checksum <= wrap_add(checksum, in);
                    end
                end
                S_WRITE: begin
                    if (last_addr) begin
                        Address <= '0;
                        vsum    <= '0;
                    end else begin
                        Address <= Address + ADDR_ONE;
                    end
                end
                S_VERIFY: begin
                    vsum    <= wrap_add(vsum, Mem_out);
                    Address <= Address + ADDR_ONE;
                end
                S_CHECK: begin
                    err <= (vsum != checksum);
                end
                default: begin
                end
            endcase
        end
    end

endmodule
